alg_sched: RTL and testbench

ALG_SCHED -- requirements
Module: alg_sched

---
 rtl/alg_sched.sv | 209 ++++++++++++++++++++
 tb/tb_alg_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alg_sched.sv
// Round-robin scheduler sharing one multi-cycle alg_unit between two requesters.
// Optional result cache enabled by defining ALG_RESULT_CACHE_EN.

package lc3b_types;
    typedef logic [15:0] lc3b_word;
    localparam logic [2:0] op_mul = 3'b001;
endpackage

module alg_sched
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  lc3b_word   opA0,
    input  lc3b_word   opB0,
    input  lc3b_word   opA1,
    input  lc3b_word   opB1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    output logic       done0,
    output logic       done1,
    output lc3b_word   hi0,
    output lc3b_word   lo0,
    output lc3b_word   hi1,
    output lc3b_word   lo1,
    output lc3b_word   unit_opA,
    output lc3b_word   unit_opB,
    output logic [2:0] unit_op,
    input  lc3b_word   unit_hi,
    input  lc3b_word   unit_lo
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             ptr_nxt;
    logic             gnt;
    logic             gnt_nxt;
    logic             take;
    logic             hit;
    lc3b_word         hit_hi;
    lc3b_word         hit_lo;
    lc3b_word         sel_a;
    lc3b_word         sel_b;
    logic [2:0]       sel_op;
    logic [2:0]       op_q;
    logic [2:0]       op_nxt;
    logic [2:0]       unit_op_nxt;
    logic             done0_nxt;
    logic             done1_nxt;
    logic             res_we;
    lc3b_word         res_hi;
    lc3b_word         res_lo;
    logic             mul_cmpl;

`ifdef ALG_RESULT_CACHE_EN
    lc3b_word   c_a;
    lc3b_word   c_b;
    lc3b_word   c_hi;
    lc3b_word   c_lo;
    logic [2:0] c_op;
    logic       c_vld;
`endif

    assign mul_cmpl = (state == BUSY) && (cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, operand selection and next state
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        take      = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            take = 1'b1;
            if (req0 && req1) begin
                gnt_nxt = ptr;
                ptr_nxt = ~ptr;
            end else begin
                gnt_nxt = req1;
            end
        end
        sel_a  = gnt_nxt ? opA1 : opA0;
        sel_b  = gnt_nxt ? opB1 : opB0;
        sel_op = gnt_nxt ? op1  : op0;
`ifdef ALG_RESULT_CACHE_EN
        hit    = c_vld && (sel_op == op_mul) && (c_op == sel_op)
                 && (c_a == sel_a) && (c_b == sel_b);
        hit_hi = c_hi;
        hit_lo = c_lo;
`else
        hit    = 1'b0;
        hit_hi = '0;
        hit_lo = '0;
`endif
        case (state)
            IDLE: if (take) state_nxt = (sel_op != op_mul || hit) ? DONE : BUSY;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        res_we = 1'b0;
        res_hi = '0;
        res_lo = '0;
        if (take && state_nxt == DONE) begin
            res_we = 1'b1;
            if (hit) begin
                res_hi = hit_hi;
                res_lo = hit_lo;
            end
        end else if (mul_cmpl) begin
            res_we = 1'b1;
            res_hi = unit_hi;
            res_lo = unit_lo;
        end
        op_nxt      = take ? sel_op : op_q;
        unit_op_nxt = (state_nxt == BUSY) ? op_nxt : 3'b000;
        done0_nxt   = (state_nxt == DONE) && !gnt_nxt;
        done1_nxt   = (state_nxt == DONE) && gnt_nxt;
    end

    // Latched request, latency counter and per-port results
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            ptr      <= 1'b0;
            gnt      <= 1'b0;
            op_q     <= '0;
            unit_opA <= '0;
            unit_opB <= '0;
            unit_op  <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            hi0      <= '0;
            lo0      <= '0;
            hi1      <= '0;
            lo1      <= '0;
        end else begin
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            op_q    <= op_nxt;
            unit_op <= unit_op_nxt;
            done0   <= done0_nxt;
            done1   <= done1_nxt;
            if (take) begin
                unit_opA <= sel_a;
                unit_opB <= sel_b;
                cnt      <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (res_we) begin
                if (gnt_nxt) begin
                    hi1 <= res_hi;
                    lo1 <= res_lo;
                end else begin
                    hi0 <= res_hi;
                    lo0 <= res_lo;
                end
            end
        end
    end

`ifdef ALG_RESULT_CACHE_EN
    // Single-entry memo of the most recent multiply completed by the unit
    always_ff @(posedge clk) begin
        if (reset) begin
            c_a   <= '0;
            c_b   <= '0;
            c_op  <= '0;
            c_hi  <= '0;
            c_lo  <= '0;
            c_vld <= 1'b0;
        end else if (mul_cmpl) begin
            c_a   <= unit_opA;
            c_b   <= unit_opB;
            c_op  <= op_q;
            c_hi  <= unit_hi;
            c_lo  <= unit_lo;
            c_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alg_sched.sv
// Scoreboard bench for alg_sched with a latency-accurate multiplier model.
module tb_alg_sched;
    import lc3b_types::*;

    localparam int unsigned LATENCY = 4;
    localparam int L = int'(LATENCY);
    localparam logic [2:0] OP_MUL = op_mul;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    lc3b_word   opA0, opB0, opA1, opB1;
    logic [2:0] op0, op1;
    logic       done0, done1;
    lc3b_word   hi0, lo0, hi1, lo1;
    lc3b_word   unit_opA, unit_opB;
    logic [2:0] unit_op;
    lc3b_word   unit_hi, unit_lo;

    typedef struct {
        lc3b_word hi;
        lc3b_word lo;
        int       due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   stable = 0;

    alg_sched #(.LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .opA0(opA0), .opB0(opB0), .opA1(opA1), .opB1(opB1),
        .op0(op0), .op1(op1),
        .done0(done0), .done1(done1),
        .hi0(hi0), .lo0(lo0), .hi1(hi1), .lo1(lo1),
        .unit_opA(unit_opA), .unit_opB(unit_opB), .unit_op(unit_op),
        .unit_hi(unit_hi), .unit_lo(unit_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product valid only after LATENCY cycles of stable mul request
    always @(posedge clk) stable <= (unit_op == OP_MUL) ? stable + 1 : 0;

    always_comb begin
        logic [31:0] prod;
        prod = 32'(unit_opA) * 32'(unit_opB);
        if (unit_op == OP_MUL && stable >= L - 1) begin
            unit_hi = prod[31:16];
            unit_lo = prod[15:0];
        end else begin
            unit_hi = 16'hDEAD;
            unit_lo = 16'hBEEF;
        end
    end

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic exp_t model(lc3b_word a, lc3b_word b, logic [2:0] op, int due);
        exp_t        e;
        logic [31:0] p;
        p     = (op == OP_MUL) ? 32'(a) * 32'(b) : 32'h0;
        e.hi  = p[31:16];
        e.lo  = p[15:0];
        e.due = due;
        return e;
    endfunction

    // Monitor: pop expected result on every done pulse
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (done0 && done1) chk("done_overlap", 1, 0);
            if (done0) begin
                if (q0.size() == 0) chk("spurious_done0", 1, 0);
                else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("hi0", hi0, e.hi);
                    chk("lo0", lo0, e.lo);
                    if (e.due >= 0) chk("done0_cycle", cyc, e.due);
                end
            end
            if (done1) begin
                if (q1.size() == 0) chk("spurious_done1", 1, 0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("hi1", hi1, e.hi);
                    chk("lo1", lo1, e.lo);
                    if (e.due >= 0) chk("done1_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_done(input int p, output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((p == 0) ? done0 : done1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk((p == 0) ? "timeout_done0" : "timeout_done1", 0, 1);
    endtask

    // Issue one request on port p, hold it until done, optionally drop req
    task automatic drive(input int p, input lc3b_word a, input lc3b_word b,
                         input logic [2:0] op, input int due, input bit drop);
        bit got;
        if (p == 0) begin
            opA0 = a; opB0 = b; op0 = op; req0 = 1'b1;
            q0.push_back(model(a, b, op, due));
        end else begin
            opA1 = a; opB1 = b; op1 = op; req1 = 1'b1;
            q1.push_back(model(a, b, op, due));
        end
        wait_done(p, got);
        if (drop || !got) begin
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_hi0"}, hi0, 0);
        chk({tag, "_lo0"}, lo0, 0);
        chk({tag, "_hi1"}, hi1, 0);
        chk({tag, "_lo1"}, lo1, 0);
        chk({tag, "_unit_opA"}, unit_opA, 0);
        chk({tag, "_unit_opB"}, unit_opB, 0);
        chk({tag, "_unit_op"}, unit_op, 0);
    endtask

    task automatic requester(input int p, input int n);
        lc3b_word   a, b;
        logic [2:0] op;
        bit         drop;
        for (int k = 0; k < n; k++) begin
            a = lc3b_word'($urandom);
            b = lc3b_word'($urandom);
            if ($urandom_range(4) == 0) begin
                a = 16'h0003;
                b = 16'h0004;
            end
            op = OP_MUL;
            if ($urandom_range(3) == 0) begin
                op = 3'($urandom_range(7));
                if (op == OP_MUL) op = 3'b000;
            end
            drop = ($urandom_range(3) != 0);
            drive(p, a, b, op, -1, drop);
            if (drop) repeat ($urandom_range(3)) @(negedge clk);
        end
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin
        int  d0, d1;
        bit  got;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        opA0 = '0; opB0 = '0; opA1 = '0; opB1 = '0;
        op0 = '0; op1 = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Single multiply, full latency
        drive(0, 16'h0003, 16'h0004, OP_MUL, cyc + 1 + L, 1'b1);
        repeat (2) @(negedge clk);

        // Simultaneous requests: port 0 first after reset
        d0 = cyc + 1 + L;
        d1 = cyc + 3 + 2 * L;
        fork
            drive(0, 16'h0002, 16'h0005, OP_MUL, d0, 1'b1);
            drive(1, 16'hFFFF, 16'hFFFF, OP_MUL, d1, 1'b1);
        join
        repeat (2) @(negedge clk);

        // Second simultaneous pair: pointer rotated to port 1
        d1 = cyc + 1 + L;
        d0 = cyc + 3 + 2 * L;
        fork
            drive(0, 16'h0007, 16'h0009, OP_MUL, d0, 1'b1);
            drive(1, 16'h1234, 16'h0010, OP_MUL, d1, 1'b1);
        join
        repeat (2) @(negedge clk);

        // Non-multiply completes after one edge with zero result
        drive(0, 16'h0055, 16'h0066, 3'b111, cyc + 1, 1'b1);
        repeat (2) @(negedge clk);

        // Request withdrawn right after acceptance still completes
        opA0 = 16'h0006; opB0 = 16'h0007; op0 = OP_MUL; req0 = 1'b1;
        q0.push_back(model(16'h0006, 16'h0007, OP_MUL, cyc + 1 + L));
        @(negedge clk);
        req0 = 1'b0;
        wait_done(0, got);
        repeat (2) @(negedge clk);

        // Reset two cycles into BUSY aborts the operation
        opA0 = 16'h0009; opB0 = 16'h0009; op0 = OP_MUL; req0 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        reset = 1'b0;
        repeat (L + 3) @(negedge clk);

        drive(0, 16'h0003, 16'h0004, OP_MUL, cyc + 1 + L, 1'b1);
        repeat (2) @(negedge clk);
`ifdef ALG_RESULT_CACHE_EN
        drive(0, 16'h0003, 16'h0004, OP_MUL, cyc + 1, 1'b1);
`else
        drive(0, 16'h0003, 16'h0004, OP_MUL, cyc + 1 + L, 1'b1);
`endif
        repeat (2) @(negedge clk);

        // Randomized concurrent traffic
        fork
            requester(0, 40);
            requester(1, 40);
        join
        repeat (L + 4) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
